qt_vector_multiply: RTL and testbench

Consumer of the serial Q-transpose stream in the matrix-inversion datapath. The block loads a 3-element right-hand-side vector b and requests the 9-element Q^T stream with a one-cycle start pulse. It multiply-accumulates the stream against b and emits y = Q^T·b serially, one row result at a time, for the back-substitution stage. It drives `start_transpose` and receives `transpose_out` on the Q-transpose interface.

---
 rtl/qt_vector_multiply.sv | 145 ++++++++++++++
 tb/tb_qt_vector_multiply.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qt_vector_multiply.sv
// qt_vector_multiply: loads b, requests the serial Q^T stream, emits y = Q^T*b.
// Ports: CLK, RST; b_in, b_valid, qt_ready, transpose_out in; start_transpose, y_out, y_valid, y_last, busy out.
module qt_vector_multiply #(
  parameter int WORDLEN            = 16,
  parameter int FRACTION_WIDTH     = 12,
  parameter int MATRIX_ELEMENT_NUM = 9
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WORDLEN-1:0] b_in,
  input  logic               b_valid,
  input  logic               qt_ready,
  input  logic [WORDLEN-1:0] transpose_out,
  output logic               start_transpose,
  output logic [WORDLEN-1:0] y_out,
  output logic               y_valid,
  output logic               y_last,
  output logic               busy
);

  localparam int KW = $clog2(MATRIX_ELEMENT_NUM);

  typedef enum logic [1:0] {
    LOAD_B,
    WAIT_QT,
    ISSUE,
    RECV
  } state_t;

  state_t state_q, state_d;

  logic [WORDLEN-1:0] b0_q, b1_q, b2_q;
  logic [WORDLEN-1:0] acc_q;
  logic [1:0]         cnt_q;
  logic [KW-1:0]      k_q;
  logic [1:0]         col_q;
  logic [1:0]         row_q;

  logic [WORDLEN-1:0]          b_sel;
  logic signed [2*WORDLEN-1:0] prod;
  logic [WORDLEN-1:0]          p;
  logic [WORDLEN-1:0]          sum;
  logic                        last_k;

  always_comb begin
    b_sel = b2_q;
    unique case (col_q)
      2'd0:    b_sel = b0_q;
      2'd1:    b_sel = b1_q;
      default: b_sel = b2_q;
    endcase
  end

  // Full-width signed product, then drop the fraction bits (floor).
  assign prod   = $signed(transpose_out) * $signed(b_sel);
  assign p      = WORDLEN'(prod >>> FRACTION_WIDTH);
  assign sum    = acc_q + p;
  assign last_k = (k_q == KW'(MATRIX_ELEMENT_NUM - 1));
  assign busy   = (state_q != LOAD_B);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LOAD_B;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD_B: begin
        if (b_valid && cnt_q == 2'd2) state_d = WAIT_QT;
      end
      WAIT_QT: begin
        if (qt_ready) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = RECV;
      end
      RECV: begin
        if (last_k) state_d = LOAD_B;
      end
      default: state_d = LOAD_B;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      b0_q            <= '0;
      b1_q            <= '0;
      b2_q            <= '0;
      acc_q           <= '0;
      cnt_q           <= '0;
      k_q             <= '0;
      col_q           <= '0;
      row_q           <= '0;
      start_transpose <= 1'b0;
      y_out           <= '0;
      y_valid         <= 1'b0;
      y_last          <= 1'b0;
    end else begin
      start_transpose <= 1'b0;
      y_valid         <= 1'b0;
      y_last          <= 1'b0;
      unique case (state_q)
        LOAD_B: begin
          if (b_valid) begin
            unique case (cnt_q)
              2'd0:    b0_q <= b_in;
              2'd1:    b1_q <= b_in;
              default: b2_q <= b_in;
            endcase
            cnt_q <= (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
          end
        end
        WAIT_QT: begin
          if (qt_ready) start_transpose <= 1'b1;
        end
        ISSUE: begin
          acc_q <= '0;
          k_q   <= '0;
          col_q <= '0;
          row_q <= '0;
        end
        RECV: begin
          k_q <= k_q + KW'(1);
          if (col_q == 2'd2) begin
            y_out   <= sum;
            y_valid <= 1'b1;
            y_last  <= (row_q == 2'd2);
            acc_q   <= '0;
            col_q   <= 2'd0;
            row_q   <= row_q + 2'd1;
          end else begin
            acc_q <= sum;
            col_q <= col_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qt_vector_multiply.sv
// tb_qt_vector_multiply: directed self-checking bench for qt_vector_multiply.
// Drives b loads and the Q^T stream, checks y, handshake timing and reset.
module tb_qt_vector_multiply;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] b_in = '0;
  logic        b_valid = 1'b0;
  logic        qt_ready = 1'b0;
  logic [15:0] transpose_out = '0;
  logic        start_transpose;
  logic [15:0] y_out;
  logic        y_valid;
  logic        y_last;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_ylast = 0;
  int t_start = 0;

  logic [15:0] qt_v [9];
  logic [15:0] b_v  [3];
  logic [15:0] y_e  [3];

  qt_vector_multiply #(
    .WORDLEN(16),
    .FRACTION_WIDTH(12),
    .MATRIX_ELEMENT_NUM(9)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .b_in(b_in),
    .b_valid(b_valid),
    .qt_ready(qt_ready),
    .transpose_out(transpose_out),
    .start_transpose(start_transpose),
    .y_out(y_out),
    .y_valid(y_valid),
    .y_last(y_last),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic set_identity();
    qt_v = '{16'd4096, 16'd0, 16'd0,
             16'd0, 16'd4096, 16'd0,
             16'd0, 16'd0, 16'd4096};
    b_v  = '{16'd4096, 16'd8192, 16'hF000};
    y_e  = '{16'd4096, 16'd8192, 16'hF000};
  endtask

  task automatic run_txn(input string nm, input bit hold,
                         input bit noise, input bit b2b);
    int row;
    logic exp_v;
    qt_ready = hold;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1;
      b_in    = b_v[i];
      tick();
    end
    b_valid = noise;
    b_in    = 16'h1234;
    checks++;
    if (busy !== 1'b1 || start_transpose !== 1'b0) begin
      errors++;
      $display("FAIL %s wait_qt: busy=%b start=%b, want busy=1 start=0",
               nm, busy, start_transpose);
    end
    qt_ready = 1'b1;
    tick();
    checks++;
    if (start_transpose !== 1'b1) begin
      errors++;
      $display("FAIL %s start: got %b want 1", nm, start_transpose);
    end
    t_start = cyc;
    if (b2b) begin
      checks++;
      if (t_start - last_ylast != 4) begin
        errors++;
        $display("FAIL %s b2b_gap: got %0d want 4", nm, t_start - last_ylast);
      end
    end
    qt_ready      = 1'b0;
    transpose_out = 16'h7777;
    tick();
    checks++;
    if (start_transpose !== 1'b0) begin
      errors++;
      $display("FAIL %s start_width: got %b want 0", nm, start_transpose);
    end
    row = 0;
    for (int k = 0; k < 9; k++) begin
      transpose_out = qt_v[k];
      tick();
      if (k == 8) b_valid = 1'b0;
      exp_v = (k % 3 == 2);
      checks++;
      if (y_valid !== exp_v || (!exp_v && y_last !== 1'b0)) begin
        errors++;
        $display("FAIL %s valid_k%0d: y_valid=%b y_last=%b want valid=%b",
                 nm, k, y_valid, y_last, exp_v);
      end
      checks++;
      if (busy !== (k != 8)) begin
        errors++;
        $display("FAIL %s busy_k%0d: got %b want %b", nm, k, busy, k != 8);
      end
      if (exp_v) begin
        checks++;
        if (y_out !== y_e[row] || y_last !== (row == 2)) begin
          errors++;
          $display("FAIL %s y%0d: got %h last=%b want %h last=%b",
                   nm, row, y_out, y_last, y_e[row], row == 2);
        end
        if (row == 2) last_ylast = cyc;
        row++;
      end
    end
    transpose_out = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if ({start_transpose, y_valid, y_last, busy} !== 4'b0 || y_out !== 16'd0) begin
      errors++;
      $display("FAIL reset: start=%b yv=%b yl=%b busy=%b y=%h want all 0",
               start_transpose, y_valid, y_last, busy, y_out);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || start_transpose !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b start=%b want 0", busy, start_transpose);
    end
  endtask

  task automatic test_identity();
    set_identity();
    run_txn("identity", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_uniform();
    for (int i = 0; i < 9; i++) qt_v[i] = 16'd2048;
    b_v = '{16'd4096, 16'd4096, 16'd4096};
    y_e = '{16'd6144, 16'd6144, 16'd6144};
    run_txn("uniform", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    qt_v = '{16'd16384, 16'd16384, 16'd16384,
             16'd0, 16'd0, 16'd0,
             16'd0, 16'd0, 16'd0};
    b_v  = '{16'd8192, 16'd8192, 16'd8192};
    y_e  = '{16'h8000, 16'd0, 16'd0};
    run_txn("wrap", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_truncate();
    qt_v = '{16'd1, 16'd0, 16'd0,
             16'hFFFF, 16'd0, 16'd0,
             16'd3, 16'd3, 16'd3};
    b_v  = '{16'd4095, 16'd1, 16'd2048};
    y_e  = '{16'd0, 16'hFFFF, 16'd3};
    run_txn("truncate", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    set_identity();
    run_txn("ready_early", 1'b1, 1'b0, 1'b0);
    set_identity();
    run_txn("b_noise", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_recv();
    set_identity();
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1;
      b_in    = b_v[i];
      tick();
    end
    b_valid  = 1'b0;
    qt_ready = 1'b1;
    tick();
    qt_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      transpose_out = qt_v[k];
      tick();
    end
    transpose_out = qt_v[4];
    RST = 1'b1;
    #1;
    checks++;
    if ({start_transpose, y_valid, y_last, busy} !== 4'b0 || y_out !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: start=%b yv=%b yl=%b busy=%b y=%h want all 0",
               start_transpose, y_valid, y_last, busy, y_out);
    end
    tick();
    RST = 1'b0;
    transpose_out = '0;
    tick();
    set_identity();
    run_txn("after_reset", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) qt_v[i] = 16'd2048;
    b_v = '{16'd4096, 16'd4096, 16'd4096};
    y_e = '{16'd6144, 16'd6144, 16'd6144};
    run_txn("b2b_first", 1'b0, 1'b0, 1'b0);
    qt_v = '{16'd0, 16'd4096, 16'd0,
             16'd4096, 16'd0, 16'd0,
             16'd0, 16'd0, 16'hF000};
    b_v  = '{16'd4096, 16'd8192, 16'd12288};
    y_e  = '{16'd8192, 16'd4096, 16'hD000};
    run_txn("b2b_second", 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_uniform();
    test_wrap();
    test_truncate();
    test_ignored_inputs();
    test_reset_mid_recv();
    test_back_to_back();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
